// File: rtl/uart_pkg.sv
// Shared types and constants for the arbitrated UART transmitter.
// Optional feature macro: UART_PARITY_EN (adds an even-parity bit, 11-bit frame).
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    // 100 MHz system clock divided down to 9600 baud.
    localparam int CLK_DIV_9600 = 10417;

`ifdef UART_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

endpackage

// File: rtl/uart_tx_shifter.sv
// Frame serialiser: baud counter, bit index, shift register, registered txd and FSM.
// Accepts a byte on i_load while idle; pulses o_done on the final tick of the stop bit.
// Optional feature macro: UART_PARITY_EN (inserts an even-parity bit before STOP).
module uart_tx_shifter
    import uart_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_9600,
    parameter int DATA_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_txd,
    output logic              o_busy,
    output logic              o_done
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_W - 1);

    uart_state_e       r_state;
    uart_state_e       w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [BIT_W-1:0]  r_bit_idx;
    logic [DATA_W-1:0] r_shift;
    logic              r_parity;
    logic              r_txd;
    logic              w_tick;
    logic              w_done;
    logic              w_txd_next;

    assign w_tick = (r_cnt == '0);

    // Next-state decode; every state lasts one full baud period ending on a tick.
    always_comb begin
        w_state_next = r_state;
        w_done       = 1'b0;
        case (r_state)
            IDLE:   if (i_load) w_state_next = START;
            START:  if (w_tick) w_state_next = DATA;
            DATA: begin
                if (w_tick && (r_bit_idx == BIT_LAST)) begin
`ifdef UART_PARITY_EN
                    w_state_next = PARITY;
`else
                    w_state_next = STOP;
`endif
                end
            end
            PARITY: if (w_tick) w_state_next = STOP;
            STOP: begin
                if (w_tick) begin
                    w_state_next = IDLE;
                    w_done       = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Line level for the next cycle; changes only on state entry or a data-bit tick.
    always_comb begin
        w_txd_next = 1'b1;
        case (w_state_next)
            IDLE:   w_txd_next = 1'b1;
            START:  w_txd_next = 1'b0;
            DATA: begin
                if (w_tick) begin
                    w_txd_next = (r_state == START) ? r_shift[0] : r_shift[1];
                end else begin
                    w_txd_next = r_txd;
                end
            end
            PARITY: w_txd_next = r_parity;
            STOP:   w_txd_next = 1'b1;
            default: w_txd_next = 1'b1;
        endcase
    end

    // State register; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Baud counter, latched byte copy and registered line driver.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt     <= CNT_RELOAD;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_parity  <= 1'b0;
            r_txd     <= 1'b1;
        end else begin
            if (r_state == IDLE) begin
                r_cnt <= CNT_RELOAD;
                if (i_load) begin
                    r_shift   <= i_data;
                    r_parity  <= ^i_data;
                    r_bit_idx <= '0;
                end
            end else begin
                r_cnt <= w_tick ? CNT_RELOAD : (r_cnt - 1'b1);
            end
            if ((r_state == DATA) && w_tick) begin
                r_shift   <= r_shift >> 1;
                r_bit_idx <= r_bit_idx + 1'b1;
            end
            r_txd <= w_txd_next;
        end
    end

    assign o_txd  = r_txd;
    assign o_busy = (r_state != IDLE);
    assign o_done = w_done;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Two-source byte arbiter in front of a single 8N1 UART transmitter.
// req1 has fixed priority when sw=1, otherwise sources alternate via rr_ptr.
// Optional feature macro: UART_PARITY_EN (passed through to the serialiser).
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_9600,
    parameter int DATA_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sw,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              txd,
    output logic              busy,
    output logic [1:0]        grant
);

    logic              r_rr_ptr;
    logic [1:0]        r_grant;
    logic              w_pick0;
    logic              w_pick1;
    logic              w_acc0;
    logic              w_acc1;
    logic              w_load;
    logic [DATA_W-1:0] w_load_data;
    logic              w_busy;
    logic              w_done;

    // Winner selection, only meaningful while the line is idle.
    always_comb begin
        w_pick1 = req1_valid && (!req0_valid || sw || r_rr_ptr);
        w_pick0 = req0_valid && !w_pick1;
        req0_ready  = !w_busy && w_pick0 && rst;
        req1_ready  = !w_busy && w_pick1 && rst;
        w_acc0      = req0_valid && req0_ready;
        w_acc1      = req1_valid && req1_ready;
        w_load      = w_acc0 || w_acc1;
        w_load_data = w_acc1 ? req1_data : req0_data;
    end

    // Grant owner and round-robin pointer; the pointer moves to the loser on accept.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rr_ptr <= 1'b0;
            r_grant  <= 2'b00;
        end else if (w_load) begin
            r_grant  <= {w_acc1, w_acc0};
            r_rr_ptr <= w_acc0;
        end else if (w_done) begin
            r_grant  <= 2'b00;
        end
    end

    uart_tx_shifter #(
        .CLK_DIV (CLK_DIV),
        .DATA_W  (DATA_W)
    ) u_shifter (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_load),
        .i_data (w_load_data),
        .o_txd  (txd),
        .o_busy (w_busy),
        .o_done (w_done)
    );

    assign busy  = w_busy;
    assign grant = r_grant;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with CLK_DIV=4.
// Optional feature macro: UART_PARITY_EN (bench expects 11-bit frames when defined).
module tb_uart_tx_arbiter;

    localparam int CDIV = 4;
`ifdef UART_PARITY_EN
    localparam int NBITS    = 11;
    localparam bit PAR      = 1'b1;
    localparam int EXP_BUSY = 44;
    localparam int EXP_GAP  = 45;
`else
    localparam int NBITS    = 10;
    localparam bit PAR      = 1'b0;
    localparam int EXP_BUSY = 40;
    localparam int EXP_GAP  = 41;
`endif
    localparam int FRAME_CYC = NBITS * CDIV;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sw  = 1'b0;
    logic       v0  = 1'b0;
    logic       v1  = 1'b0;
    logic [7:0] d0  = 8'h00;
    logic [7:0] d1  = 8'h00;
    logic       r0;
    logic       r1;
    logic       txd;
    logic       busy;
    logic [1:0] grant;

    uart_tx_arbiter #(.CLK_DIV(CDIV), .DATA_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .sw         (sw),
        .req0_valid (v0),
        .req0_data  (d0),
        .req0_ready (r0),
        .req1_valid (v1),
        .req1_data  (d1),
        .req1_ready (r1),
        .txd        (txd),
        .busy       (busy),
        .grant      (grant)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: an active frame is a list of bit levels, each CDIV cycles long.
    bit         m_active = 1'b0;
    int         m_pos    = 0;
    logic [1:0] m_owner  = 2'b00;
    logic [7:0] m_byte   = 8'h00;
    bit         m_rr     = 1'b0;

    function automatic logic m_bit(input int pos, input logic [7:0] b);
        int idx;
        idx = pos / CDIV;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (PAR && idx == 9) return ^b;
        return 1'b1;
    endfunction

    // Monitor: running totals and frame-start log.
    int         cyc        = 0;
    int         r0_total   = 0;
    int         r1_total   = 0;
    int         busy_total = 0;
    logic       prev_busy  = 1'b0;
    logic [1:0] gq[$];
    int         tq[$];

    always @(negedge clk) begin
        cyc++;
        if (r0) r0_total++;
        if (r1) r1_total++;
        if (busy === 1'b1) busy_total++;
        if (busy === 1'b1 && prev_busy !== 1'b1) begin
            gq.push_back(grant);
            tq.push_back(cyc);
        end
        prev_busy = busy;
    end

    // Line decoder sampling the middle of each bit period.
    bit         d_act  = 1'b0;
    int         d_cnt  = 0;
    logic [7:0] d_byte = 8'h00;
    logic       d_par  = 1'b0;
    logic [7:0] dec_q[$];
    logic       par_q[$];

    always @(negedge clk) begin
        if (!rst) begin
            d_act = 1'b0;
        end else if (!d_act) begin
            if (txd === 1'b0) begin
                d_act = 1'b1;
                d_cnt = 0;
            end
        end else begin
            d_cnt++;
            for (int i = 0; i < 8; i++) begin
                if (d_cnt == 4 * (i + 1) + 2) d_byte[i] = txd;
            end
            if (d_cnt == 4 * 9 + 2) d_par = txd;
            if (d_cnt == FRAME_CYC - 1) begin
                d_act = 1'b0;
                dec_q.push_back(d_byte);
                par_q.push_back(d_par);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_accept();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if ((r0 && v0) || (r1 && v1)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    int b_r0, b_r1, b_busy, b_g, b_dec;

    initial begin
        fork
            // Per-cycle compare of every output against the model.
            forever begin
                int   win;
                logic e_txd;
                @(negedge clk);
                win = -1;
                if (v0 && !v1) win = 0;
                else if (v1 && !v0) win = 1;
                else if (v0 && v1) win = sw ? 1 : (m_rr ? 1 : 0);
                e_txd = m_active ? m_bit(m_pos, m_byte) : 1'b1;
                chk("cyc_txd",   txd,   e_txd);
                chk("cyc_busy",  busy,  m_active);
                chk("cyc_grant", grant, m_active ? m_owner : 2'b00);
                chk("cyc_ready0", r0, rst && !m_active && win == 0);
                chk("cyc_ready1", r1, rst && !m_active && win == 1);
                if (!rst) begin
                    m_active = 1'b0;
                    m_rr     = 1'b0;
                end else if (m_active) begin
                    m_pos++;
                    if (m_pos == FRAME_CYC) m_active = 1'b0;
                end else if (win >= 0) begin
                    m_active = 1'b1;
                    m_pos    = 0;
                    m_owner  = (win == 1) ? 2'b10 : 2'b01;
                    m_byte   = (win == 1) ? d1 : d0;
                    m_rr     = (win == 0);
                end
            end
        join_none

        // 1: reset held 3 cycles with both sources requesting.
        rst = 1'b0; v0 = 1'b1; v1 = 1'b1; d0 = 8'h11; d1 = 8'h22;
        b_r0 = r0_total; b_r1 = r1_total;
        tick(3);
        chk("t1_txd", txd, 1);
        chk("t1_busy", busy, 0);
        chk("t1_grant", grant, 0);
        chk("t1_ready_seen", r0_total - b_r0 + r1_total - b_r1, 0);
        v0 = 1'b0; v1 = 1'b0; rst = 1'b1;
        tick(2);

        // 2: req0 sends 0x55 alone.
        b_r0 = r0_total; b_busy = busy_total; b_g = gq.size(); b_dec = dec_q.size();
        d0 = 8'h55; v0 = 1'b1;
        wait_accept();
        v0 = 1'b0;
        tick(FRAME_CYC + 5);
        chk("t2_ready_cycles", r0_total - b_r0, 1);
        chk("t2_busy_cycles", busy_total - b_busy, EXP_BUSY);
        chk("t2_grant", gq[b_g], 2'b01);
        chk("t2_frames", dec_q.size() - b_dec, 1);
        chk("t2_byte", dec_q[b_dec], 8'h55);
        $display("txn t2 byte=%02h grant=%b", dec_q[b_dec], gq[b_g]);

        // 3: round-robin with both valid, starting from a fresh pointer.
        rst = 1'b0; tick(1); rst = 1'b1;
        sw = 1'b0; d0 = 8'hA5; d1 = 8'h3C;
        b_g = gq.size(); b_dec = dec_q.size();
        v0 = 1'b1; v1 = 1'b1;
        repeat (3) wait_accept();
        v0 = 1'b0; v1 = 1'b0;
        tick(FRAME_CYC + 5);
        chk("t3_g0", gq[b_g],     2'b01);
        chk("t3_g1", gq[b_g + 1], 2'b10);
        chk("t3_g2", gq[b_g + 2], 2'b01);
        chk("t3_gap0", tq[b_g + 1] - tq[b_g],     EXP_GAP);
        chk("t3_gap1", tq[b_g + 2] - tq[b_g + 1], EXP_GAP);
        chk("t3_b0", dec_q[b_dec],     8'hA5);
        chk("t3_b1", dec_q[b_dec + 1], 8'h3C);
        chk("t3_b2", dec_q[b_dec + 2], 8'hA5);
        for (int i = 0; i < 3; i++)
            $display("txn t3 byte=%02h grant=%b", dec_q[b_dec + i], gq[b_g + i]);

        // 4: fixed priority, req1 always wins.
        sw = 1'b1; d0 = 8'hA5; d1 = 8'h5A;
        b_r0 = r0_total; b_r1 = r1_total; b_g = gq.size(); b_dec = dec_q.size();
        v0 = 1'b1; v1 = 1'b1;
        repeat (3) wait_accept();
        v0 = 1'b0; v1 = 1'b0;
        tick(FRAME_CYC + 5);
        chk("t4_ready0", r0_total - b_r0, 0);
        chk("t4_ready1", r1_total - b_r1, 3);
        for (int i = 0; i < 3; i++) begin
            chk("t4_grant", gq[b_g + i], 2'b10);
            chk("t4_byte", dec_q[b_dec + i], 8'h5A);
            $display("txn t4 byte=%02h grant=%b", dec_q[b_dec + i], gq[b_g + i]);
        end

        // 5: reset pulse during data bit 3 aborts the frame.
        sw = 1'b0; d0 = 8'h00;
        b_dec = dec_q.size();
        v0 = 1'b1;
        wait_accept();
        v0 = 1'b0;
        tick(16);
        chk("t5_pre_txd", txd, 0);
        chk("t5_pre_busy", busy, 1);
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        chk("t5_abort_txd", txd, 1);
        chk("t5_abort_busy", busy, 0);
        chk("t5_abort_grant", grant, 0);
        tick(3);
        b_g = gq.size();
        d1 = 8'h81; v1 = 1'b1;
        wait_accept();
        v1 = 1'b0;
        tick(FRAME_CYC + 5);
        chk("t5_frames", dec_q.size() - b_dec, 1);
        chk("t5_byte", dec_q[b_dec], 8'h81);
        chk("t5_grant", gq[b_g], 2'b10);
        $display("txn t5 byte=%02h grant=%b", dec_q[b_dec], gq[b_g]);

`ifdef UART_PARITY_EN
        // 6: parity frame for 0x07 (three ones -> parity bit 1).
        b_busy = busy_total; b_dec = dec_q.size();
        d0 = 8'h07; v0 = 1'b1;
        wait_accept();
        v0 = 1'b0;
        tick(FRAME_CYC + 5);
        chk("t6_busy_cycles", busy_total - b_busy, 44);
        chk("t6_byte", dec_q[b_dec], 8'h07);
        chk("t6_parity", par_q[b_dec], 1);
        $display("txn t6 byte=%02h parity=%b", dec_q[b_dec], par_q[b_dec]);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
